// File: rtl/cache_bus_arbiter.sv
// N-port burst arbiter: grants one cache-side master at a time for a full
// transaction onto a single downstream burst bus (round-robin or fixed priority).
module cache_bus_arbiter #(
   parameter int unsigned PORT_NUM   = 2,
   parameter int unsigned ADDR_WIDTH = 32,
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned LEN_WIDTH  = 8,
   parameter int unsigned ARB_MODE   = 0
) (
   input  logic                             clk,
   input  logic                             rst_n,
   input  logic [PORT_NUM-1:0]              up_req_valid_i,
   output logic [PORT_NUM-1:0]              up_req_ready_o,
   input  logic [PORT_NUM-1:0]              up_req_write_i,
   input  logic [PORT_NUM*ADDR_WIDTH-1:0]   up_req_addr_i,
   input  logic [PORT_NUM*LEN_WIDTH-1:0]    up_req_len_i,
   input  logic [PORT_NUM*DATA_WIDTH-1:0]   up_wdata_i,
   input  logic [PORT_NUM-1:0]              up_wvalid_i,
   output logic [PORT_NUM-1:0]              up_wready_o,
   output logic [DATA_WIDTH-1:0]            up_rdata_o,
   output logic [PORT_NUM-1:0]              up_rvalid_o,
   output logic                             up_rlast_o,
   output logic [PORT_NUM-1:0]              up_bvalid_o,
   output logic                             dn_req_valid_o,
   input  logic                             dn_req_ready_i,
   output logic                             dn_req_write_o,
   output logic [ADDR_WIDTH-1:0]            dn_req_addr_o,
   output logic [LEN_WIDTH-1:0]             dn_req_len_o,
   output logic [DATA_WIDTH-1:0]            dn_wdata_o,
   output logic                             dn_wvalid_o,
   output logic                             dn_wlast_o,
   input  logic                             dn_wready_i,
   input  logic [DATA_WIDTH-1:0]            dn_rdata_i,
   input  logic                             dn_rvalid_i,
   input  logic                             dn_rlast_i,
   input  logic                             dn_bvalid_i,
   output logic                             busy_o
);

   localparam int unsigned IDX_W = (PORT_NUM > 1) ? $clog2(PORT_NUM) : 1;

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_REQ   = 3'd1;
   localparam logic [2:0] S_READ  = 3'd2;
   localparam logic [2:0] S_WRITE = 3'd3;
   localparam logic [2:0] S_WRESP = 3'd4;

   logic [2:0]            r_state;
   logic [2:0]            w_state_nxt;
   logic [IDX_W-1:0]      r_owner;
   logic [IDX_W-1:0]      r_rr_ptr;
   logic                  r_write;
   logic [ADDR_WIDTH-1:0] r_addr;
   logic [LEN_WIDTH-1:0]  r_len;
   logic [LEN_WIDTH-1:0]  r_cnt;

   logic [IDX_W-1:0]      w_base;
   logic [IDX_W-1:0]      w_win;
   logic [IDX_W-1:0]      w_rr_nxt;
   logic                  w_found;
   int                    w_k;
   logic [PORT_NUM-1:0]   w_win_oh;
   logic [PORT_NUM-1:0]   w_owner_oh;
   logic                  w_own_wvalid;
   logic [DATA_WIDTH-1:0] w_own_wdata;
   logic                  w_wbeat;
   logic                  w_wlast;

   // Fixed priority always searches from port 0; round-robin from the pointer
   assign w_base = (ARB_MODE == 1) ? '0 : r_rr_ptr;

   always_comb begin : winner_search
      w_found = 1'b0;
      w_win   = '0;
      w_k     = 0;
      for (int i = 0; i < int'(PORT_NUM); i++) begin
         w_k = (int'(w_base) + i) % int'(PORT_NUM);
         if (!w_found && ((up_req_valid_i & (PORT_NUM'(1) << w_k)) != '0)) begin
            w_found = 1'b1;
            w_win   = IDX_W'(w_k);
         end
      end
   end

   assign w_rr_nxt     = (w_win == IDX_W'(PORT_NUM - 1)) ? '0 : w_win + 1'b1;
   assign w_win_oh     = PORT_NUM'(1) << w_win;
   assign w_owner_oh   = PORT_NUM'(1) << r_owner;
   assign w_own_wvalid = |(up_wvalid_i & w_owner_oh);
   assign w_own_wdata  = DATA_WIDTH'(up_wdata_i >> (int'(r_owner) * int'(DATA_WIDTH)));
   assign w_wlast      = (r_cnt == r_len);
   assign w_wbeat      = (r_state == S_WRITE) && w_own_wvalid && dn_wready_i;

   always_ff @(posedge clk or negedge rst_n) begin : state_reg
      if (!rst_n) r_state <= S_IDLE;
      else        r_state <= w_state_nxt;
   end

   // Next state plus owner-routed beat paths (combinational, zero latency)
   always_comb begin : fsm_comb
      w_state_nxt    = r_state;
      up_req_ready_o = '0;
      up_wready_o    = '0;
      up_rdata_o     = '0;
      up_rvalid_o    = '0;
      up_rlast_o     = 1'b0;
      up_bvalid_o    = '0;
      dn_req_valid_o = 1'b0;
      dn_wdata_o     = '0;
      dn_wvalid_o    = 1'b0;
      dn_wlast_o     = 1'b0;
      busy_o         = (r_state != S_IDLE);
      case (r_state)
         S_IDLE: begin
            if (w_found && rst_n) up_req_ready_o = w_win_oh;
            if (w_found) w_state_nxt = S_REQ;
         end
         S_REQ: begin
            dn_req_valid_o = 1'b1;
            if (dn_req_ready_i) w_state_nxt = r_write ? S_WRITE : S_READ;
         end
         S_READ: begin
            up_rdata_o  = dn_rdata_i;
            up_rvalid_o = dn_rvalid_i ? w_owner_oh : '0;
            up_rlast_o  = dn_rlast_i;
            if (dn_rvalid_i && dn_rlast_i) w_state_nxt = S_IDLE;
         end
         S_WRITE: begin
            up_wready_o = dn_wready_i ? w_owner_oh : '0;
            dn_wvalid_o = w_own_wvalid;
            dn_wdata_o  = w_own_wdata;
            dn_wlast_o  = w_wlast;
            if (w_wbeat && w_wlast) w_state_nxt = S_WRESP;
         end
         S_WRESP: begin
            up_bvalid_o = dn_bvalid_i ? w_owner_oh : '0;
            if (dn_bvalid_i) w_state_nxt = S_IDLE;
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // Latch the winning request and track write beats
   always_ff @(posedge clk or negedge rst_n) begin : datapath
      if (!rst_n) begin
         r_owner  <= '0;
         r_rr_ptr <= '0;
         r_write  <= 1'b0;
         r_addr   <= '0;
         r_len    <= '0;
         r_cnt    <= '0;
      end else begin
         if (r_state == S_IDLE && w_found) begin
            r_owner <= w_win;
            r_write <= |(up_req_write_i & w_win_oh);
            r_addr  <= ADDR_WIDTH'(up_req_addr_i >> (int'(w_win) * int'(ADDR_WIDTH)));
            r_len   <= LEN_WIDTH'(up_req_len_i >> (int'(w_win) * int'(LEN_WIDTH)));
            if (ARB_MODE == 0) r_rr_ptr <= w_rr_nxt;
         end
         if (r_state == S_REQ)        r_cnt <= '0;
         else if (w_wbeat && !w_wlast) r_cnt <= r_cnt + 1'b1;
      end
   end

   assign dn_req_write_o = r_write;
   assign dn_req_addr_o  = r_addr;
   assign dn_req_len_o   = r_len;

endmodule

// File: tb/tb_cache_bus_arbiter.sv
// Directed bench for cache_bus_arbiter: a 4-port round-robin instance driven
// from a transaction table plus a 2-port fixed-priority instance.
module tb_cache_bus_arbiter;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   // 4-port round-robin instance
   logic [3:0]   req_valid, req_ready, req_write, wvalid, wready, rvalid, bvalid;
   logic [127:0] req_addr, wdata;
   logic [31:0]  req_len, rdata, dn_req_addr, dn_wdata, dn_rdata;
   logic         rlast, dn_req_valid, dn_req_ready, dn_req_write, dn_wvalid, dn_wlast;
   logic         dn_wready, dn_rvalid, dn_rlast, dn_bvalid, busy;
   logic [7:0]   dn_req_len;

   cache_bus_arbiter #(.PORT_NUM(4), .ARB_MODE(0)) u_rr (
      .clk(clk), .rst_n(rst_n),
      .up_req_valid_i(req_valid), .up_req_ready_o(req_ready), .up_req_write_i(req_write),
      .up_req_addr_i(req_addr), .up_req_len_i(req_len), .up_wdata_i(wdata),
      .up_wvalid_i(wvalid), .up_wready_o(wready), .up_rdata_o(rdata),
      .up_rvalid_o(rvalid), .up_rlast_o(rlast), .up_bvalid_o(bvalid),
      .dn_req_valid_o(dn_req_valid), .dn_req_ready_i(dn_req_ready),
      .dn_req_write_o(dn_req_write), .dn_req_addr_o(dn_req_addr), .dn_req_len_o(dn_req_len),
      .dn_wdata_o(dn_wdata), .dn_wvalid_o(dn_wvalid), .dn_wlast_o(dn_wlast),
      .dn_wready_i(dn_wready), .dn_rdata_i(dn_rdata), .dn_rvalid_i(dn_rvalid),
      .dn_rlast_i(dn_rlast), .dn_bvalid_i(dn_bvalid), .busy_o(busy)
   );

   // 2-port fixed-priority instance
   logic [1:0]  f_valid, f_ready, f_write, f_wvalid, f_wready, f_rvalid, f_bvalid;
   logic [63:0] f_addr, f_wdata;
   logic [15:0] f_len;
   logic [31:0] f_rdata, f_dn_addr, f_dn_wdata;
   logic        f_rlast, f_dn_valid, f_dn_ready, f_dn_write, f_dn_wvalid, f_dn_wlast;
   logic        f_dn_rvalid, f_dn_rlast;
   logic        f_busy;
   logic [7:0]  f_dn_len;
   logic        f_zero = 1'b0;
   logic [31:0] f_zero32 = 32'd0;

   cache_bus_arbiter #(.PORT_NUM(2), .ARB_MODE(1)) u_fix (
      .clk(clk), .rst_n(rst_n),
      .up_req_valid_i(f_valid), .up_req_ready_o(f_ready), .up_req_write_i(f_write),
      .up_req_addr_i(f_addr), .up_req_len_i(f_len), .up_wdata_i(f_wdata),
      .up_wvalid_i(f_wvalid), .up_wready_o(f_wready), .up_rdata_o(f_rdata),
      .up_rvalid_o(f_rvalid), .up_rlast_o(f_rlast), .up_bvalid_o(f_bvalid),
      .dn_req_valid_o(f_dn_valid), .dn_req_ready_i(f_dn_ready),
      .dn_req_write_o(f_dn_write), .dn_req_addr_o(f_dn_addr), .dn_req_len_o(f_dn_len),
      .dn_wdata_o(f_dn_wdata), .dn_wvalid_o(f_dn_wvalid), .dn_wlast_o(f_dn_wlast),
      .dn_wready_i(f_zero), .dn_rdata_i(f_zero32), .dn_rvalid_i(f_dn_rvalid),
      .dn_rlast_i(f_dn_rlast), .dn_bvalid_i(f_zero), .busy_o(f_busy)
   );

   typedef struct {
      logic [3:0]  valid;
      int          exp_port;
      logic        write;
      logic [31:0] addr;
      logic [7:0]  len;
      int          stall;
   } vec_t;

   vec_t tbl [8];
   int   n_tests = 0;
   int   n_fail  = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   // One complete transaction on the round-robin instance, starting in IDLE
   task automatic txn(input vec_t v, input int id);
      int         p;
      logic [3:0] oh;
      p  = v.exp_port;
      oh = 4'b0001 << p;
      for (int q = 0; q < 4; q++) begin
         req_addr[q*32 +: 32] = v.addr + 32'(q - p) * 32'h1000;
         req_len[q*8 +: 8]    = (q == p) ? v.len : v.len + 8'd1;
         req_write[q]         = (q == p) ? v.write : !v.write;
      end
      req_valid = v.valid;
      #1;
      chk("grant", 64'(req_ready), 64'(oh));
      chk("busy_idle", 64'(busy), 64'd0);
      tick();
      req_valid    = v.valid & ~oh;
      dn_req_ready = 1'b0;
      #1;
      chk("dn_req_valid", 64'(dn_req_valid), 64'd1);
      chk("dn_req_addr", 64'(dn_req_addr), 64'(v.addr));
      chk("dn_req_len", 64'(dn_req_len), 64'(v.len));
      chk("dn_req_write", 64'(dn_req_write), 64'(v.write));
      chk("no_regrant", 64'(req_ready), 64'd0);
      chk("busy_req", 64'(busy), 64'd1);
      tick();
      dn_req_ready = 1'b1;
      #1;
      chk("dn_req_hold", 64'(dn_req_valid), 64'd1);
      tick();
      dn_req_ready = 1'b0;
      req_valid    = 4'b0000;
      if (!v.write) begin
         #1;
         chk("rvalid_gap", 64'(rvalid), 64'd0);
         tick();
         for (int b = 0; b <= int'(v.len); b++) begin
            dn_rvalid = 1'b1;
            dn_rdata  = 32'hA500_0000 ^ (32'(id) << 16) ^ 32'(b);
            dn_rlast  = (b == int'(v.len));
            #1;
            chk("rvalid", 64'(rvalid), 64'(oh));
            chk("rdata", 64'(rdata), 64'(32'hA500_0000 ^ (32'(id) << 16) ^ 32'(b)));
            chk("rlast", 64'(rlast), 64'(b == int'(v.len)));
            tick();
         end
         dn_rvalid = 1'b0;
         dn_rlast  = 1'b0;
         #1;
         chk("busy_after_read", 64'(busy), 64'd0);
         chk("rvalid_after", 64'(rvalid), 64'd0);
      end else begin
         for (int b = 0; b <= int'(v.len); b++) begin
            wvalid = oh | (4'b0001 << ((p + 1) % 4));
            for (int q = 0; q < 4; q++) wdata[q*32 +: 32] = {8'(q), 8'(id), 16'(b)};
            for (int s = 0; s < v.stall; s++) begin
               dn_wready = 1'b0;
               #1;
               chk("wvalid_stall", 64'(dn_wvalid), 64'd1);
               chk("wready_stall", 64'(wready), 64'd0);
               tick();
            end
            dn_wready = 1'b1;
            #1;
            chk("wready", 64'(wready), 64'(oh));
            chk("dn_wdata", 64'(dn_wdata), 64'({8'(p), 8'(id), 16'(b)}));
            chk("dn_wlast", 64'(dn_wlast), 64'(b == int'(v.len)));
            tick();
         end
         wvalid    = 4'b0000;
         dn_wready = 1'b0;
         #1;
         chk("wresp_busy", 64'(busy), 64'd1);
         chk("bvalid_early", 64'(bvalid), 64'd0);
         chk("dn_wvalid_off", 64'(dn_wvalid), 64'd0);
         tick();
         dn_bvalid = 1'b1;
         #1;
         chk("bvalid", 64'(bvalid), 64'(oh));
         tick();
         dn_bvalid = 1'b0;
         #1;
         chk("busy_after_write", 64'(busy), 64'd0);
         chk("bvalid_pulse", 64'(bvalid), 64'd0);
      end
   endtask

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation still running at %0t", $time);
      $fatal(1, "watchdog expired");
   end

   initial begin : main
      vec_t rv;
      tbl[0] = '{4'b0010, 1, 1'b0, 32'h1C00_0000, 8'd3,   0};
      tbl[1] = '{4'b0011, 0, 1'b0, 32'h0000_4000, 8'd0,   0};
      tbl[2] = '{4'b0011, 1, 1'b1, 32'h8000_0100, 8'd1,   2};
      tbl[3] = '{4'b0011, 0, 1'b1, 32'h8000_0200, 8'd0,   0};
      tbl[4] = '{4'b1100, 2, 1'b0, 32'h2000_0000, 8'd1,   0};
      tbl[5] = '{4'b1101, 3, 1'b1, 32'h3000_0040, 8'd2,   1};
      tbl[6] = '{4'b1101, 0, 1'b0, 32'h0000_0080, 8'd0,   0};
      tbl[7] = '{4'b0001, 0, 1'b1, 32'h4000_0000, 8'd255, 0};

      rst_n = 1'b0;
      req_valid = 4'b1111; req_write = '0; req_addr = '0; req_len = '0;
      wdata = '0; wvalid = '0; dn_req_ready = 1'b0; dn_wready = 1'b0;
      dn_rdata = '0; dn_rvalid = 1'b0; dn_rlast = 1'b0; dn_bvalid = 1'b0;
      f_valid = '0; f_write = '0; f_addr = '0; f_len = '0; f_wdata = '0;
      f_wvalid = '0; f_dn_ready = 1'b0; f_dn_rvalid = 1'b0; f_dn_rlast = 1'b0;
      tick();
      tick();
      #1;
      chk("rst_ready", 64'(req_ready), 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_dn_req_valid", 64'(dn_req_valid), 64'd0);
      chk("rst_dn_req_addr", 64'(dn_req_addr), 64'd0);
      chk("rst_dn_req_len", 64'(dn_req_len), 64'd0);
      chk("rst_dn_wvalid", 64'(dn_wvalid), 64'd0);
      chk("rst_dn_wlast", 64'(dn_wlast), 64'd0);
      req_valid = 4'b0000;
      rst_n = 1'b1;
      tick();

      for (int i = 0; i < 8; i++) txn(tbl[i], i);

      // Stray read beat / write response while idle must be dropped
      dn_rvalid = 1'b1; dn_rlast = 1'b1; dn_bvalid = 1'b1;
      #1;
      chk("stray_rvalid", 64'(rvalid), 64'd0);
      chk("stray_rlast", 64'(rlast), 64'd0);
      chk("stray_bvalid", 64'(bvalid), 64'd0);
      tick();
      chk("stray_busy", 64'(busy), 64'd0);
      dn_rvalid = 1'b0; dn_rlast = 1'b0; dn_bvalid = 1'b0;
      tick();

      // Reset asserted during the second read beat
      req_len[2*8 +: 8] = 8'd3; req_write[2] = 1'b0; req_addr[2*32 +: 32] = 32'h6000_0000;
      req_valid = 4'b0100;
      #1;
      chk("mid_grant", 64'(req_ready), 64'h4);
      tick();
      req_valid = 4'b0000;
      dn_req_ready = 1'b1;
      tick();
      dn_req_ready = 1'b0;
      dn_rvalid = 1'b1; dn_rdata = 32'h1111_0001;
      #1;
      chk("mid_beat1", 64'(rvalid), 64'h4);
      tick();
      dn_rdata = 32'h1111_0002;
      #1;
      chk("mid_beat2", 64'(rvalid), 64'h4);
      #1;
      rst_n = 1'b0;
      #1;
      chk("rst_rvalid", 64'(rvalid), 64'd0);
      chk("rst_rdata", 64'(rdata), 64'd0);
      chk("rst_busy_async", 64'(busy), 64'd0);
      chk("rst_req_addr_async", 64'(dn_req_addr), 64'd0);
      chk("rst_req_valid_async", 64'(dn_req_valid), 64'd0);
      @(posedge clk);
      @(negedge clk);
      dn_rvalid = 1'b0;
      rst_n = 1'b1;
      tick();

      // All four ports requesting after reset: order 0,1,2,3,0
      for (int k = 0; k < 5; k++) begin
         rv = '{4'b1111, k % 4, 1'b0, 32'h5000_0000 + 32'(k) * 32'h10, 8'd0, 0};
         txn(rv, 20 + k);
      end

      // Fixed priority: port 0 wins every time while it holds valid
      f_addr = {32'hF100_0000, 32'hF000_0000};
      f_valid = 2'b11;
      for (int k = 0; k < 3; k++) begin
         #1;
         chk("fix_grant", 64'(f_ready), 64'h1);
         tick();
         chk("fix_addr", 64'(f_dn_addr), 64'hF000_0000);
         f_dn_ready = 1'b1;
         tick();
         f_dn_ready = 1'b0;
         f_dn_rvalid = 1'b1; f_dn_rlast = 1'b1;
         #1;
         chk("fix_rvalid", 64'(f_rvalid), 64'h1);
         tick();
         f_dn_rvalid = 1'b0; f_dn_rlast = 1'b0;
      end
      f_valid = 2'b00;
      tick();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
